// File: rtl/mac_bitserial_pkg.sv
// Shared types and constants for the bit-serial MAC sequencer.
package mac_bitserial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } ctrl_state_t;

    localparam int COL_BITS     = 3;
    localparam int NUM_COLS     = 8;
    localparam int DATA_WIDTH   = 8;
    localparam int RESULT_WIDTH = DATA_WIDTH + 16;

    // Magnitude of a two's-complement weight; -128 maps to 0x80.
    function automatic logic [DATA_WIDTH-1:0] sm_mag(input logic signed [DATA_WIDTH-1:0] w);
        return w[DATA_WIDTH-1] ? (~w + 1'b1) : w;
    endfunction

endpackage

// File: rtl/mac_bitserial_ctrl_lowest_set_col.sv
// Priority encoder: index of the lowest set bit of an 8-bit column mask.
module lowest_set_col
    import mac_bitserial_pkg::*;
(
    input  logic [NUM_COLS-1:0] vec,
    output logic [COL_BITS-1:0] idx,
    output logic                none
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx  = '0;
        none = (vec == '0);
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = COL_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/mac_bitserial_ctrl.sv
// Sequencer for one signed 8-lane bit-serial MAC: accepts a job, walks the
// non-zero weight bit-columns lowest first, then returns the accumulated result.
module mac_bitserial_ctrl
    import mac_bitserial_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_act    [VEC_LENGTH],
    input  logic signed [DATA_WIDTH-1:0] in_weight [VEC_LENGTH],
    output logic                         mac_reset,
    output logic signed [DATA_WIDTH-1:0] mac_act   [VEC_LENGTH],
    output logic [VEC_LENGTH-1:0]        mac_sign,
    output logic [VEC_LENGTH-1:0]        mac_w_bit,
    output logic [COL_BITS-1:0]          mac_column_idx,
    input  logic signed [DATA_WIDTH+15:0] mac_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH+15:0] out_result,
    output logic [3:0]                   out_cycles
);

    ctrl_state_t                  state_q, state_d;
    logic signed [DATA_WIDTH-1:0] act_q [VEC_LENGTH];
    logic signed [DATA_WIDTH-1:0] act_d [VEC_LENGTH];
    logic [DATA_WIDTH-1:0]        mag_q [VEC_LENGTH];
    logic [DATA_WIDTH-1:0]        mag_d [VEC_LENGTH];
    logic [VEC_LENGTH-1:0]        sign_q, sign_d;
    logic [NUM_COLS-1:0]          mask_q, mask_d;
    logic [3:0]                   cycles_q, cycles_d;
    logic                         mac_reset_q, mac_reset_d;
    logic                         in_ready_q, in_ready_d;
    logic                         out_valid_q, out_valid_d;
    logic [VEC_LENGTH-1:0]        w_bit_q, w_bit_d;
    logic [VEC_LENGTH-1:0]        sign_out_q, sign_out_d;
    logic [COL_BITS-1:0]          col_q, col_d;

    logic [DATA_WIDTH-1:0]        in_mag [VEC_LENGTH];
    logic [VEC_LENGTH-1:0]        in_sign;
    logic [NUM_COLS-1:0]          in_colmask;
    logic [COL_BITS-1:0]          col_sel;
    logic                         col_none;

    // Sign-magnitude conversion of the offered weights, one lane per instance.
    for (genvar gi = 0; gi < VEC_LENGTH; gi++) begin : g_lane
        assign in_mag[gi]  = sm_mag(in_weight[gi]);
        assign in_sign[gi] = in_weight[gi][DATA_WIDTH-1];
    end

    // Columns that carry at least one set magnitude bit in any lane.
    always_comb begin
        in_colmask = '0;
        for (int i = 0; i < VEC_LENGTH; i++) begin
            in_colmask = in_colmask | in_mag[i][NUM_COLS-1:0];
        end
    end

    // One encoder on the remaining mask selects the next column and flags the end.
    lowest_set_col u_col_sel (
        .vec  (mask_q),
        .idx  (col_sel),
        .none (col_none)
    );

    // Next-state and next-output logic; outputs are registered with the state.
    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        mag_d       = mag_q;
        sign_d      = sign_q;
        mask_d      = mask_q;
        cycles_d    = cycles_q;
        mac_reset_d = mac_reset_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        w_bit_d     = '0;
        sign_out_d  = '0;
        col_d       = '0;
        case (state_q)
            ST_IDLE: begin
                mac_reset_d = 1'b1;
                in_ready_d  = 1'b1;
                if (in_valid) begin
                    state_d     = ST_LOAD;
                    act_d       = in_act;
                    mag_d       = in_mag;
                    sign_d      = in_sign;
                    mask_d      = in_colmask;
                    cycles_d    = '0;
                    mac_reset_d = 1'b0;
                    in_ready_d  = 1'b0;
                end
            end
            // LOAD and RUN share the column walk: the remaining mask decides.
            ST_LOAD, ST_RUN: begin
                if (col_none) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    state_d    = ST_RUN;
                    col_d      = col_sel;
                    sign_out_d = sign_q;
                    for (int i = 0; i < VEC_LENGTH; i++) begin
                        w_bit_d[i] = mag_q[i][col_sel];
                    end
                    mask_d   = mask_q & ~(NUM_COLS'(1) << col_sel);
                    cycles_d = cycles_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    mac_reset_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            act_q       <= '{default: '0};
            mag_q       <= '{default: '0};
            sign_q      <= '0;
            mask_q      <= '0;
            cycles_q    <= '0;
            mac_reset_q <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            w_bit_q     <= '0;
            sign_out_q  <= '0;
            col_q       <= '0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            mag_q       <= mag_d;
            sign_q      <= sign_d;
            mask_q      <= mask_d;
            cycles_q    <= cycles_d;
            mac_reset_q <= mac_reset_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            w_bit_q     <= w_bit_d;
            sign_out_q  <= sign_out_d;
            col_q       <= col_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign mac_reset      = mac_reset_q;
    assign mac_act        = act_q;
    assign mac_sign       = sign_out_q;
    assign mac_w_bit      = w_bit_q;
    assign mac_column_idx = col_q;
    assign out_valid      = out_valid_q;
    assign out_result     = mac_result;
    assign out_cycles     = cycles_q;

endmodule
